// File: rtl/aes_pkg.sv
// Shared AES-state types and defaults.
// Used by the lane serializer and the lane select logic.
package aes_pkg;

  typedef enum logic {
    LANE_COL = 1'b0,
    LANE_ROW = 1'b1
  } lane_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ser_state_e;

  localparam int AES_BYTE_BITS = 8;
  localparam int AES_LANES     = 4;

  // Lane index width; a single lane still gets a one-bit index.
  function automatic int lane_idx_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/state_lane_select.sv
// Combinational lane picker: returns column or row idx of a square LANES x LANES state.
// Row words place byte(c*LANES + r) at byte position c, so the highest column lands in the MSBs.
module state_lane_select
  import aes_pkg::*;
#(
  parameter  int BYTE_BITS  = AES_BYTE_BITS,
  parameter  int LANES      = AES_LANES,
  localparam int WORD_BITS  = BYTE_BITS * LANES,
  localparam int BLOCK_BITS = WORD_BITS * LANES,
  localparam int IDX_BITS   = lane_idx_bits(LANES)
) (
  input  logic [BLOCK_BITS-1:0] i_block,
  input  lane_mode_e            i_mode,
  input  logic [IDX_BITS-1:0]   i_idx,
  output logic [WORD_BITS-1:0]  o_word
);

  always_comb begin
    o_word = '0;
    for (int l = 0; l < LANES; l++) begin
      if (i_idx == IDX_BITS'(l)) begin
        for (int k = 0; k < LANES; k++) begin
          if (i_mode == LANE_ROW) begin
            o_word[k*BYTE_BITS +: BYTE_BITS] = i_block[(k*LANES + l)*BYTE_BITS +: BYTE_BITS];
          end else begin
            o_word[k*BYTE_BITS +: BYTE_BITS] = i_block[(l*LANES + k)*BYTE_BITS +: BYTE_BITS];
          end
        end
      end
    end
  end

endmodule

// File: rtl/state_lane_serializer.sv
// Takes one packed state block per input handshake and streams it out one lane per output handshake.
// States: IDLE | waiting for a block ; BUSY | presenting lane r_idx of the held block
module state_lane_serializer
  import aes_pkg::*;
#(
  parameter  int BYTE_BITS  = AES_BYTE_BITS,
  parameter  int LANES      = AES_LANES,
  localparam int WORD_BITS  = BYTE_BITS * LANES,
  localparam int BLOCK_BITS = WORD_BITS * LANES,
  localparam int IDX_BITS   = lane_idx_bits(LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BLOCK_BITS-1:0] in_block,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_BITS-1:0]  out_data,
  output logic [IDX_BITS-1:0]   out_idx,
  output logic                  out_last
);

  if (LANES < 1 || BYTE_BITS < 1) begin : g_bad_param
    $error("state_lane_serializer: LANES and BYTE_BITS must both be at least 1");
  end

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(LANES - 1);

  ser_state_e            r_state;
  ser_state_e            w_state_nxt;
  logic [BLOCK_BITS-1:0] r_block;
  lane_mode_e            r_mode;
  logic [IDX_BITS-1:0]   r_idx;
  logic [IDX_BITS-1:0]   w_idx_nxt;
  logic                  w_load;
  logic                  w_busy;
  logic                  w_at_last;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic [WORD_BITS-1:0]  w_word;

  // Outputs are forced quiet while rst is held, not just after the reset edge.
  assign w_busy    = (r_state == ST_BUSY) && !rst;
  assign w_at_last = w_busy && (r_idx == LAST_IDX);
  assign in_ready  = !rst && ((r_state == ST_IDLE) || (w_at_last && out_ready));
  assign out_valid = w_busy;
  assign out_last  = w_at_last;
  assign out_idx   = rst ? '0 : r_idx;
  assign out_data  = rst ? '0 : w_word;
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;

  state_lane_select #(
    .BYTE_BITS (BYTE_BITS),
    .LANES     (LANES)
  ) u_select (
    .i_block (r_block),
    .i_mode  (r_mode),
    .i_idx   (r_idx),
    .o_word  (w_word)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_in_hs) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_out_hs) begin
          if (r_idx == LAST_IDX) begin
            if (w_in_hs) begin
              w_load    = 1'b1;
              w_idx_nxt = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_block <= '0;
      r_mode  <= LANE_COL;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_load) begin
        r_block <= in_block;
        r_mode  <= lane_mode_e'(in_mode);
      end
    end
  end

endmodule

// File: tb/tb_state_lane_serializer.sv
// Bench for state_lane_serializer: default 8x4 instance against a lane-queue model,
// plus LANES=2/BYTE_BITS=4 and LANES=1 instances with directed steps.
module tb_state_lane_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;

  logic         in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
  logic [127:0] in_block = '0;
  logic         in_ready, out_valid, out_last;
  logic [31:0]  out_data;
  logic [1:0]   out_idx;

  logic         a_in_valid = 1'b0, a_in_mode = 1'b0, a_out_ready = 1'b0;
  logic [15:0]  a_in_block = '0;
  logic         a_in_ready, a_out_valid, a_out_last;
  logic [7:0]   a_out_data;
  logic [0:0]   a_out_idx;

  logic         b_in_valid = 1'b0, b_in_mode = 1'b0, b_out_ready = 1'b0;
  logic [7:0]   b_in_block = '0;
  logic         b_in_ready, b_out_valid, b_out_last;
  logic [7:0]   b_out_data;
  logic [0:0]   b_out_idx;

  state_lane_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last));

  state_lane_serializer #(.BYTE_BITS(4), .LANES(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_block(a_in_block),
    .in_mode(a_in_mode), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_idx(a_out_idx), .out_last(a_out_last));

  state_lane_serializer #(.BYTE_BITS(8), .LANES(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_block(b_in_block),
    .in_mode(b_in_mode), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .out_last(b_out_last));

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] d;
    int          idx;
    bit          last;
  } lane_t;

  lane_t q[$];
  bit    prev_rst = 1'b1;

  localparam logic [127:0] BLK  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] BLK2 = 128'hffeeddcc_bbaa9988_77665544_33221100;

  // Lane i of an L x L state of B-bit bytes: column i is bytes i*L+k, row i is bytes k*L+i.
  function automatic logic [31:0] exp_lane(input logic [127:0] b, input bit m, input int i,
                                           input int L, input int B);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < L; k++) begin
      int src;
      src = m ? (k*L + i) : (i*L + k);
      for (int t = 0; t < B; t++) w[k*B + t] = b[src*B + t];
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [127:0] b, input bit m, input bit ordy, input bit r);
    bit e_ir, e_ov;
    @(negedge clk);
    rst = r; in_valid = v; in_block = b; in_mode = m; out_ready = ordy;
    #1;
    e_ir = !r && (q.size() == 0 || (q.size() == 1 && ordy));
    e_ov = !r && (q.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    if (e_ov) begin
      chk("out_data", out_data, q[0].d);
      chk("out_idx", 32'(out_idx), 32'(q[0].idx));
      chk("out_last", 32'(out_last), 32'(q[0].last));
    end else begin
      chk("out_last_idle", 32'(out_last), 32'd0);
      if (r || prev_rst) begin
        chk("out_data_rst", out_data, 32'd0);
        chk("out_idx_rst", 32'(out_idx), 32'd0);
      end
    end
    prev_rst = r;
    if (r) begin
      q.delete();
    end else begin
      if (e_ov && ordy) void'(q.pop_front());
      if (v && e_ir)
        for (int i = 0; i < 4; i++) q.push_back('{exp_lane(b, m, i, 4, 8), i, (i == 3)});
    end
  endtask

  initial begin
    // reset and idle
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 0);

    // column lanes
    step(1, BLK, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, BLK2, 1, 1, 0);
    step(0, '0, 0, 1, 0);

    // row lanes
    step(1, BLK, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // back-to-back column then row block with in_valid held
    step(1, BLK, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, BLK2, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // random traffic and backpressure, inputs churning while busy
    for (int i = 0; i < 120; i++)
      step(bit'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 12; i++) step(0, '0, 0, 1, 0);

    // reset after the idx-1 handshake, then a fresh block
    step(1, BLK2, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 0, 0);
    step(1, BLK, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // LANES=2/BYTE_BITS=4 row block and LANES=1 register slice
    @(negedge clk);
    a_in_valid = 1; a_in_block = 16'hba98; a_in_mode = 1; a_out_ready = 1;
    b_in_valid = 1; b_in_block = 8'h5a;    b_in_mode = 0; b_out_ready = 1;
    #1;
    chk("a_in_ready_idle", 32'(a_in_ready), 32'd1);
    chk("b_in_ready_idle", 32'(b_in_ready), 32'd1);
    chk("a_out_valid_idle", 32'(a_out_valid), 32'd0);

    @(negedge clk);
    a_in_valid = 0; b_in_valid = 0; b_out_ready = 0;
    #1;
    chk("a_out_valid0", 32'(a_out_valid), 32'd1);
    chk("a_out_data0", 32'(a_out_data), exp_lane(128'(16'hba98), 1, 0, 2, 4));
    chk("a_out_idx0", 32'(a_out_idx), 32'd0);
    chk("a_out_last0", 32'(a_out_last), 32'd0);
    chk("a_in_ready0", 32'(a_in_ready), 32'd0);
    chk("b_out_valid", 32'(b_out_valid), 32'd1);
    chk("b_out_data", 32'(b_out_data), 32'h5a);
    chk("b_out_last", 32'(b_out_last), 32'd1);
    chk("b_in_ready_stall", 32'(b_in_ready), 32'd0);

    @(negedge clk);
    b_out_ready = 1;
    #1;
    chk("a_out_data1", 32'(a_out_data), exp_lane(128'(16'hba98), 1, 1, 2, 4));
    chk("a_out_idx1", 32'(a_out_idx), 32'd1);
    chk("a_out_last1", 32'(a_out_last), 32'd1);
    chk("a_in_ready1", 32'(a_in_ready), 32'd1);
    chk("b_out_data_held", 32'(b_out_data), 32'h5a);
    chk("b_out_idx", 32'(b_out_idx), 32'd0);
    chk("b_in_ready_pass", 32'(b_in_ready), 32'd1);

    @(negedge clk);
    #1;
    chk("a_out_valid_end", 32'(a_out_valid), 32'd0);
    chk("b_out_valid_end", 32'(b_out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
